// File: rtl/keypad_entry_pkg.sv
// Shared definitions for the keypad entry path: keycodes, the matrix
// position to keycode map, debounce FSM states and a BCD helper.
package keypad_entry_pkg;

   // Digits use their own value 0..9 as keycode; function keys sit above.
   localparam logic [3:0] KEY_BACK  = 4'd10;
   localparam logic [3:0] KEY_ENTER = 4'd11;
   localparam logic [3:0] KEY_CLEAR = 4'd12;
   localparam logic [3:0] KEY_NONE  = 4'd15;

   typedef enum logic [1:0] {
      WAIT_PRESS   = 2'd0,
      CONFIRM      = 2'd1,
      WAIT_RELEASE = 2'd2,
      CONFIRM_REL  = 2'd3
   } debState_t;

   // Matrix index 4*row+col to keycode. B, C and D map to KEY_NONE.
   function automatic logic [3:0] keyMap(input logic [3:0] idx);
      logic [3:0] code;
      case (idx)
         4'd0:    code = 4'd1;
         4'd1:    code = 4'd2;
         4'd2:    code = 4'd3;
         4'd3:    code = KEY_BACK;
         4'd4:    code = 4'd4;
         4'd5:    code = 4'd5;
         4'd6:    code = 4'd6;
         4'd8:    code = 4'd7;
         4'd9:    code = 4'd8;
         4'd10:   code = 4'd9;
         4'd12:   code = KEY_CLEAR;
         4'd13:   code = 4'd0;
         4'd14:   code = KEY_ENTER;
         default: code = KEY_NONE;
      endcase
      return code;
   endfunction

   function automatic logic isDigit(input logic [3:0] code);
      return (code <= 4'd9);
   endfunction

   // Three BCD digits to binary; 10 bits so 999 still fits for range checks.
   function automatic logic [9:0] bcdToBin(input logic [11:0] bcd);
      return 10'(bcd[11:8]) * 10'd100 + 10'(bcd[7:4]) * 10'd10 + 10'(bcd[3:0]);
   endfunction

endpackage

// File: rtl/keypad_entry_debounce.sv
// Classifies each completed 16-key scan map and debounces press/release
// with a 4-state FSM, producing one key event per physical press.
module key_debounce
   import keypad_entry_pkg::*;
#(
   parameter int DEBOUNCE = 4
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        i_scanDone,
   input  logic [15:0] i_map,
   output logic        o_key_evt,
   output logic [3:0]  o_key_code
);

   localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam bit DEB_ONE = (DEBOUNCE == 1);

   debState_t     r_state;
   debState_t     w_nextState;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cntNext;
   logic [3:0]    r_key;
   logic [3:0]    w_keyNext;
   logic          w_one;
   logic [3:0]    w_idx;

   // Classify the map: exactly one key down is ONE, anything else counts as NONE.
   always_comb begin
      w_one = (i_map != 16'd0) && ((i_map & (i_map - 16'd1)) == 16'd0);
      w_idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (i_map[i]) w_idx = 4'(i);
      end
   end

   // State, scan counter and latched key index.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= WAIT_PRESS;
         r_cnt   <= '0;
         r_key   <= 4'd0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_cntNext;
         r_key   <= w_keyNext;
      end
   end

   // Next-state logic, evaluated only when a full scan has just completed.
   always_comb begin
      w_nextState = r_state;
      w_cntNext   = r_cnt;
      w_keyNext   = r_key;
      if (i_scanDone) begin
         case (r_state)
            WAIT_PRESS: begin
               if (w_one) begin
                  w_keyNext   = w_idx;
                  w_cntNext   = CNT_ONE;
                  w_nextState = DEB_ONE ? WAIT_RELEASE : CONFIRM;
               end
            end
            CONFIRM: begin
               if (w_one && (w_idx == r_key)) begin
                  if (r_cnt == DEB_LAST) begin
                     w_cntNext   = '0;
                     w_nextState = WAIT_RELEASE;
                  end else begin
                     w_cntNext = r_cnt + 1'b1;
                  end
               end else begin
                  w_cntNext   = '0;
                  w_nextState = WAIT_PRESS;
               end
            end
            WAIT_RELEASE: begin
               if (!w_one && (i_map == 16'd0 || !w_one)) begin
                  w_cntNext   = CNT_ONE;
                  w_nextState = DEB_ONE ? WAIT_PRESS : CONFIRM_REL;
               end
            end
            CONFIRM_REL: begin
               if (!w_one) begin
                  if (r_cnt == DEB_LAST) begin
                     w_cntNext   = '0;
                     w_nextState = WAIT_PRESS;
                  end else begin
                     w_cntNext = r_cnt + 1'b1;
                  end
               end else begin
                  w_cntNext   = '0;
                  w_nextState = WAIT_RELEASE;
               end
            end
            default: begin
               w_cntNext   = '0;
               w_nextState = WAIT_PRESS;
            end
         endcase
      end
   end

   // Event fires on the scan that completes the press debounce; B/C/D stay silent.
   always_comb begin
      o_key_code = keyMap(w_idx);
      o_key_evt  = 1'b0;
      if (i_scanDone && w_one && (o_key_code != KEY_NONE)) begin
         if (r_state == WAIT_PRESS && DEB_ONE) begin
            o_key_evt = 1'b1;
         end else if (r_state == CONFIRM && w_idx == r_key && r_cnt == DEB_LAST) begin
            o_key_evt = 1'b1;
         end
      end
   end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry top: column scanning, row synchronizer, debounce instance
// and the three-digit decimal entry / BCD-to-binary conversion.
module keypad_entry
   import keypad_entry_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int DEBOUNCE = 4
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [8:0]  value,
   output logic        value_valid,
   output logic [11:0] entry,
   output logic [1:0]  ndigits,
   output logic        err
);

   localparam int DW = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

   logic [3:0]    r_rowMeta;
   logic [3:0]    r_rowSync;
   logic [DW-1:0] r_divCnt;
   logic [1:0]    r_colIdx;
   logic [15:0]   r_map;
   logic [15:0]   w_mapNext;
   logic          w_tick;
   logic          w_scanDone;
   logic          w_keyEvt;
   logic [3:0]    w_keyCode;
   logic [9:0]    w_candidate;
   logic [8:0]    r_value;
   logic          r_valueValid;
   logic [11:0]   r_entry;
   logic [1:0]    r_ndigits;
   logic          r_err;

   assign w_tick      = (r_divCnt == DIV_LAST);
   assign w_scanDone  = w_tick && (r_colIdx == 2'd3);
   assign col         = ~(4'b0001 << r_colIdx);
   assign w_candidate = bcdToBin({r_entry[7:0], w_keyCode});

   assign value       = r_value;
   assign value_valid = r_valueValid;
   assign entry       = r_entry;
   assign ndigits     = r_ndigits;
   assign err         = r_err;

   // Two-flop synchronizer for the asynchronous row lines.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_rowMeta <= 4'hF;
         r_rowSync <= 4'hF;
      end else begin
         r_rowMeta <= row;
         r_rowSync <= r_rowMeta;
      end
   end

   // Merge the current column's rows into the map; bit {row,col} is 1 when pressed.
   always_comb begin
      w_mapNext = r_map;
      for (int r = 0; r < 4; r++) begin
         w_mapNext[{2'(r), r_colIdx}] = ~r_rowSync[r];
      end
   end

   // Scan divider, column pointer and press map, all advancing on the tick.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_divCnt <= '0;
         r_colIdx <= 2'd0;
         r_map    <= 16'd0;
      end else if (w_tick) begin
         r_divCnt <= '0;
         r_colIdx <= r_colIdx + 2'd1;
         r_map    <= w_mapNext;
      end else begin
         r_divCnt <= r_divCnt + 1'b1;
      end
   end

   key_debounce #(
      .DEBOUNCE(DEBOUNCE)
   ) u_debounce (
      .clock      (clock),
      .rst_n      (rst_n),
      .i_scanDone (w_scanDone),
      .i_map      (w_mapNext),
      .o_key_evt  (w_keyEvt),
      .o_key_code (w_keyCode)
   );

   // Entry editing and Enter conversion; strobes are one cycle and mutually exclusive.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_value      <= 9'd0;
         r_valueValid <= 1'b0;
         r_entry      <= 12'd0;
         r_ndigits    <= 2'd0;
         r_err        <= 1'b0;
      end else begin
         r_valueValid <= 1'b0;
         r_err        <= 1'b0;
         if (w_keyEvt) begin
            if (isDigit(w_keyCode)) begin
               if (r_ndigits == 2'd3) begin
                  r_err <= 1'b1;
               end else if (w_candidate > 10'd511) begin
                  r_err <= 1'b1;
               end else begin
                  r_entry   <= {r_entry[7:0], w_keyCode};
                  r_ndigits <= r_ndigits + 2'd1;
               end
            end else begin
               case (w_keyCode)
                  KEY_BACK: begin
                     if (r_ndigits == 2'd0) begin
                        r_err <= 1'b1;
                     end else begin
                        r_entry   <= {4'h0, r_entry[11:4]};
                        r_ndigits <= r_ndigits - 2'd1;
                     end
                  end
                  KEY_CLEAR: begin
                     r_entry   <= 12'd0;
                     r_ndigits <= 2'd0;
                  end
                  KEY_ENTER: begin
                     if (r_ndigits == 2'd0) begin
                        r_err <= 1'b1;
                     end else begin
                        r_value      <= 9'(bcdToBin(r_entry));
                        r_valueValid <= 1'b1;
                        r_entry      <= 12'd0;
                        r_ndigits    <= 2'd0;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end
      end
   end

endmodule
